// File: rtl/bsg_fpu_cmp_reduce_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : bsg_fpu_cmp_reduce_pkg                                           |
// | Desc    : Shared state encoding and canonical-qNaN helper for the reducer. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package bsg_fpu_cmp_reduce_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    MIN    = 2'd1,
    MAX    = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Exponent all ones, mantissa MSB set: 0x7E00 for e5m10.
  function automatic logic [63:0] canonical_qnan(input int e, input int m);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << e) - 64'd1;
    return (exp_ones << m) | (64'd1 << (m - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_fpu_cmp.sv
// +----------------------------------------------------------------------------+
// | Module  : bsg_fpu_cmp                                                      |
// | Desc    : IEEE min/max comparator with NaN-suppressing min/max semantics.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bsg_fpu_cmp
  import bsg_fpu_cmp_reduce_pkg::*;
#(
  parameter int e_p = 5,
  parameter int m_p = 10
) (
  input  logic [e_p+m_p:0] a_i,
  input  logic [e_p+m_p:0] b_i,
  output logic [e_p+m_p:0] min_o,
  output logic [e_p+m_p:0] max_o,
  output logic             min_max_invalid_o
);

  localparam int w_lp = 1 + e_p + m_p;
  localparam logic [w_lp-1:0] qnan_lp = w_lp'(canonical_qnan(e_p, m_p));

  logic a_nan, b_nan, a_snan, b_snan, a_lt_b;

  assign a_nan  = (&a_i[w_lp-2:m_p]) & (|a_i[m_p-1:0]);
  assign b_nan  = (&b_i[w_lp-2:m_p]) & (|b_i[m_p-1:0]);
  assign a_snan = a_nan & ~a_i[m_p-1];
  assign b_snan = b_nan & ~b_i[m_p-1];

  // Sign-magnitude total order so that -0 sorts below +0.
  assign a_lt_b = (a_i[w_lp-1] & ~b_i[w_lp-1])
                | (~a_i[w_lp-1] & ~b_i[w_lp-1] & (a_i[w_lp-2:0] < b_i[w_lp-2:0]))
                | (a_i[w_lp-1] & b_i[w_lp-1] & (a_i[w_lp-2:0] > b_i[w_lp-2:0]));

  assign min_max_invalid_o = a_snan | b_snan;

  always_comb begin
    min_o = a_lt_b ? a_i : b_i;
    max_o = a_lt_b ? b_i : a_i;
    if (a_nan & b_nan) begin
      min_o = qnan_lp;
      max_o = qnan_lp;
    end else if (a_nan) begin
      min_o = b_i;
      max_o = b_i;
    end else if (b_nan) begin
      min_o = a_i;
      max_o = a_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_fpu_cmp_reduce.sv
// +----------------------------------------------------------------------------+
// | Module  : bsg_fpu_cmp_reduce                                               |
// | Desc    : Streaming packet min/max/count/invalid reduction over IEEE       |
// |           floats. Define BSG_FPU_CMP_REDUCE_DUAL_CMP_EN for two            |
// |           comparators and one element per cycle.                           |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bsg_fpu_cmp_reduce
  import bsg_fpu_cmp_reduce_pkg::*;
#(
  parameter int e_p         = 5,
  parameter int m_p         = 10,
  parameter int len_width_p = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   v_i,
  input  logic [e_p+m_p:0]       data_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [e_p+m_p:0]       min_o,
  output logic [e_p+m_p:0]       max_o,
  output logic [len_width_p-1:0] count_o,
  output logic                   invalid_o,
  input  logic                   yumi_i
);

  localparam int w_lp = 1 + e_p + m_p;
  localparam logic [w_lp-1:0] qnan_lp = w_lp'(canonical_qnan(e_p, m_p));

  state_e                 state_q, state_d;
  logic [w_lp-1:0]        min_q, min_d;
  logic [w_lp-1:0]        max_q, max_d;
  logic [len_width_p-1:0] count_q, count_d, count_inc;
  logic                   invalid_q, invalid_d;

  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

`ifdef BSG_FPU_CMP_REDUCE_DUAL_CMP_EN
  logic [w_lp-1:0] lo_min, lo_max_unused, hi_min_unused, hi_max;
  logic            lo_inv, hi_inv;

  bsg_fpu_cmp #(.e_p(e_p), .m_p(m_p)) u_cmp_min (
    .a_i(data_i), .b_i(min_q),
    .min_o(lo_min), .max_o(lo_max_unused), .min_max_invalid_o(lo_inv)
  );

  bsg_fpu_cmp #(.e_p(e_p), .m_p(m_p)) u_cmp_max (
    .a_i(data_i), .b_i(max_q),
    .min_o(hi_min_unused), .max_o(hi_max), .min_max_invalid_o(hi_inv)
  );
`else
  logic [w_lp-1:0] op_q, op_d;
  logic            last_q, last_d;
  logic [w_lp-1:0] cmp_b, cmp_min, cmp_max;
  logic            cmp_inv;

  // One comparator: operand b tracks whichever running extreme is being updated.
  assign cmp_b = (state_q == MAX) ? max_q : min_q;

  bsg_fpu_cmp #(.e_p(e_p), .m_p(m_p)) u_cmp (
    .a_i(op_q), .b_i(cmp_b),
    .min_o(cmp_min), .max_o(cmp_max), .min_max_invalid_o(cmp_inv)
  );
`endif

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    count_d   = count_q;
    invalid_d = invalid_q;
    ready_o   = 1'b0;
    v_o       = 1'b0;
`ifndef BSG_FPU_CMP_REDUCE_DUAL_CMP_EN
    op_d      = op_q;
    last_d    = last_q;
`endif
    case (state_q)
      ACCEPT: begin
        ready_o = 1'b1;
        if (v_i) begin
`ifdef BSG_FPU_CMP_REDUCE_DUAL_CMP_EN
          min_d     = lo_min;
          max_d     = hi_max;
          invalid_d = invalid_q | lo_inv | hi_inv;
          count_d   = count_inc;
          state_d   = last_i ? DONE : ACCEPT;
`else
          op_d    = data_i;
          last_d  = last_i;
          state_d = MIN;
`endif
        end
      end
`ifndef BSG_FPU_CMP_REDUCE_DUAL_CMP_EN
      MIN: begin
        min_d     = cmp_min;
        invalid_d = invalid_q | cmp_inv;
        state_d   = MAX;
      end
      MAX: begin
        max_d     = cmp_max;
        invalid_d = invalid_q | cmp_inv;
        count_d   = count_inc;
        state_d   = last_q ? DONE : ACCEPT;
      end
`endif
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) begin
          min_d     = qnan_lp;
          max_d     = qnan_lp;
          count_d   = '0;
          invalid_d = 1'b0;
          state_d   = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCEPT;
      min_q     <= qnan_lp;
      max_q     <= qnan_lp;
      count_q   <= '0;
      invalid_q <= 1'b0;
`ifndef BSG_FPU_CMP_REDUCE_DUAL_CMP_EN
      op_q      <= '0;
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      count_q   <= count_d;
      invalid_q <= invalid_d;
`ifndef BSG_FPU_CMP_REDUCE_DUAL_CMP_EN
      op_q      <= op_d;
      last_q    <= last_d;
`endif
    end
  end

  assign min_o     = min_q;
  assign max_o     = max_q;
  assign count_o   = count_q;
  assign invalid_o = invalid_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_fpu_cmp_reduce.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_bsg_fpu_cmp_reduce                                            |
// | Desc    : Directed self-checking bench for bsg_fpu_cmp_reduce (e5m10).     |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bsg_fpu_cmp_reduce;

`ifdef BSG_FPU_CMP_REDUCE_DUAL_CMP_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif
  localparam logic [15:0] QNAN = 16'h7E00;

  logic        clk, rst_n, v_i, last_i, yumi_i;
  logic [15:0] data_i;
  logic        ready_o, v_o, invalid_o;
  logic [15:0] min_o, max_o;
  logic [7:0]  count_o;
  logic        s_ready_o, s_v_o, s_invalid_o;
  logic [15:0] s_min_o, s_max_o;
  logic [1:0]  s_count_o;

  int n_checks = 0;
  int n_errors = 0;

  bsg_fpu_cmp_reduce #(.e_p(5), .m_p(10), .len_width_p(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .ready_o(ready_o), .v_o(v_o), .min_o(min_o), .max_o(max_o),
    .count_o(count_o), .invalid_o(invalid_o), .yumi_i(yumi_i)
  );

  // Narrow-counter instance shares stimulus to exercise saturation.
  bsg_fpu_cmp_reduce #(.e_p(5), .m_p(10), .len_width_p(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .ready_o(s_ready_o), .v_o(s_v_o), .min_o(s_min_o), .max_o(s_max_o),
    .count_o(s_count_o), .invalid_o(s_invalid_o), .yumi_i(yumi_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
    v_i    = 1'b1;
    data_i = d;
    last_i = l;
    @(negedge clk);
    v_i    = 1'b0;
    last_i = 1'b0;
    data_i = 16'($urandom);
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!v_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("v_o", 32'(v_o), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                              input logic [7:0] cnt, input logic inv);
    check({tag, "_min"}, 32'(min_o), 32'(mn));
    check({tag, "_max"}, 32'(max_o), 32'(mx));
    check({tag, "_count"}, 32'(count_o), 32'(cnt));
    check({tag, "_invalid"}, 32'(invalid_o), 32'(inv));
  endtask

  task automatic pop();
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    check("pop_v_o", 32'(v_o), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n  = 1'b0;
    v_i    = 1'b0;
    last_i = 1'b0;
    yumi_i = 1'b0;
    data_i = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_v_o", 32'(v_o), 32'd0);
    check_result("rst", QNAN, QNAN, 8'd0, 1'b0);

    // yumi without a pending result must be ignored
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    check("idle_yumi_ready", 32'(ready_o), 32'd1);

    send(16'h3C00, 1'b0);
    send(16'hBC00, 1'b0);
    send(16'h4000, 1'b1);
    wait_result(lat);
    check("latency", 32'(lat), 32'(LAT - 1));
    check_result("basic", 16'hBC00, 16'h4000, 8'd3, 1'b0);
    pop();

    send(16'h7C01, 1'b0);
    send(16'h3C00, 1'b1);
    wait_result(lat);
    check_result("snan", 16'h3C00, 16'h3C00, 8'd2, 1'b1);
    pop();

    send(16'h7E00, 1'b1);
    wait_result(lat);
    check_result("qnan", 16'h7E00, 16'h7E00, 8'd1, 1'b0);
    pop();

    send(16'h0000, 1'b0);
    send(16'h8000, 1'b1);
    wait_result(lat);
    check_result("zeros", 16'h8000, 16'h0000, 8'd2, 1'b0);
    pop();

    for (int i = 0; i < 5; i++) send(16'h7C00, (i == 4));
    wait_result(lat);
    check_result("inf5", 16'h7C00, 16'h7C00, 8'd5, 1'b0);
    check("sat_count", 32'(s_count_o), 32'd3);
    check("sat_min", 32'(s_min_o), 32'h7C00);
    check("sat_max", 32'(s_max_o), 32'h7C00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_v_o", 32'(v_o), 32'd1);
      check("hold_ready", 32'(ready_o), 32'd0);
      check("hold_min", 32'(min_o), 32'h7C00);
    end
    pop();

    send(16'hC000, 1'b1);
    wait_result(lat);
    check_result("after_hold", 16'hC000, 16'hC000, 8'd1, 1'b0);
    pop();

    send(16'h3C00, 1'b0);
    send(16'hBC00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_v_o", 32'(v_o), 32'd0);
    check_result("midrst", QNAN, QNAN, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h3C00, 1'b1);
    wait_result(lat);
    check_result("post_rst", 16'h3C00, 16'h3C00, 8'd1, 1'b0);
    pop();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
